// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin grants instead of data priority.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          if_done,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       grant;
  logic       pick_d;
  logic       other_req;
  logic       tmo_hit;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q = 1 means fetch was served last
  logic ptr_q, ptr_d;

  assign pick_d = d_req && (!if_req || ptr_q);
  assign ptr_d  = grant ? !sel_d : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign busy      = (state_q != IDLE);
  assign other_req = sel_q ? if_req : d_req;
  assign tmo_hit   = busy && (cnt_q == 8'(TMO - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant = 1'b1;
          sel_d = pick_d;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) begin
          if (other_req) begin
            grant = 1'b1;
            sel_d = !sel_q;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = sel_d ? BUSY_D : BUSY_IF;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_en    = busy;
  assign sel       = sel_q;
  assign mem_we    = (state_q == BUSY_D) && d_we;
  assign mem_wdata = (state_q == BUSY_D) ? d_wdata : '0;
  assign mem_addr  = (state_q == BUSY_D)  ? d_addr  :
                     (state_q == BUSY_IF) ? if_addr : '0;
  assign rdata     = mem_rdata;

  // pulses are suppressed while reset is asserted so an aborted access stays silent
  assign if_done = rst && (state_q == BUSY_IF) && mem_ready;
  assign d_done  = rst && (state_q == BUSY_D) && mem_ready;
  assign err     = rst && tmo_hit && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a rule-level arbitration model.
// Directed scenarios followed by two randomized requester agents.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_done;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          sel;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .if_done   (if_done),
    .d_done    (d_done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  req_t if_q[$];
  req_t d_q[$];
  int   errors = 0;
  int   checks = 0;
  int   lat_mode;
  logic exp_err;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = memval(mem_addr);

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder: latency per access, junk mem_ready while idle
  initial begin : responder
    int   k;
    int   lat;
    logic last_end;
    k = 0;
    lat = 0;
    last_end = 1'b1;
    mem_ready = 1'b0;
    exp_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        k = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end else begin
        if (k == 0 || last_end) begin
          k = 0;
          if (lat_mode >= 0) lat = lat_mode;
          else if ($urandom_range(0, 7) == 0) lat = TMO + int'($urandom_range(0, 1));
          else lat = int'($urandom_range(0, TMO - 1));
          exp_err = (lat >= TMO);
        end
        mem_ready = (k == lat);
        k++;
      end
      @(negedge clk);
      last_end = if_done | d_done | err | !rst;
    end
  end

  // Monitor: reference arbitration model plus scoreboard pops
  initial begin : monitor
    int   owner;
    int   cyc;
    logic last_sel;
    logic last_data;
    logic fin;
    logic want_d;
    req_t e;
    owner = 0;
    cyc = 0;
    last_sel = 1'b0;
    last_data = 1'b1;
    forever begin
      @(negedge clk);
      fin = rst && owner != 0 && mem_ready;
      check("busy", 64'(busy), 64'(owner != 0));
      check("sel", 64'(sel), 64'(owner == 0 ? last_sel : owner == 2));
      check("if_done", 64'(if_done), 64'(fin && owner == 1));
      check("d_done", 64'(d_done), 64'(fin && owner == 2));
      check("err", 64'(err),
            64'(rst && owner != 0 && !mem_ready && cyc == TMO));
      if (owner == 0) begin
        check("idle_cmd", {mem_en, mem_we, mem_addr, mem_wdata[30:0]}, 64'd0);
      end else begin
        check("mem_en", 64'(mem_en), 64'd1);
        check("mem_we", 64'(mem_we), 64'(owner == 2 && d_we));
        check("mem_addr", 64'(mem_addr), 64'(owner == 2 ? d_addr : if_addr));
      end
      if (if_done) begin
        if (if_q.size() == 0) check("if_q_nonempty", 64'd0, 64'd1);
        else begin
          e = if_q.pop_front();
          check("if_addr_sb", 64'(mem_addr), 64'(e.addr));
          check("if_rdata", 64'(rdata), 64'(memval(e.addr)));
          check("if_no_tmo", 64'(exp_err), 64'd0);
        end
      end
      if (d_done) begin
        if (d_q.size() == 0) check("d_q_nonempty", 64'd0, 64'd1);
        else begin
          e = d_q.pop_front();
          check("d_addr_sb", 64'(mem_addr), 64'(e.addr));
          check("d_we_sb", 64'(mem_we), 64'(e.we));
          check("d_wdata_sb", 64'(mem_wdata), 64'(e.wdata));
          check("d_rdata", 64'(rdata), 64'(memval(e.addr)));
          check("d_no_tmo", 64'(exp_err), 64'd0);
        end
      end
      if (err) begin
        if (sel) begin
          if (d_q.size() == 0) check("d_q_err", 64'd0, 64'd1);
          else void'(d_q.pop_front());
        end else begin
          if (if_q.size() == 0) check("if_q_err", 64'd0, 64'd1);
          else void'(if_q.pop_front());
        end
        check("tmo_expected", 64'(exp_err), 64'd1);
      end
      if (!rst) begin
        owner = 0;
        last_sel = 1'b0;
        last_data = 1'b1;
      end else if (owner == 0) begin
        if (if_req || d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          want_d = d_req && (!if_req || !last_data);
`else
          want_d = d_req;
`endif
          owner = want_d ? 2 : 1;
          cyc = 1;
          last_sel = want_d;
          last_data = want_d;
        end
      end else if (mem_ready) begin
        if (owner == 1 ? d_req : if_req) begin
          owner = 3 - owner;
          cyc = 1;
          last_sel = (owner == 2);
          last_data = (owner == 2);
        end else begin
          owner = 0;
        end
      end else if (cyc == TMO) begin
        owner = 0;
      end else begin
        cyc++;
      end
    end
  end

  task automatic do_fetch(input logic [AW-1:0] a);
    req_t e;
    int   t;
    e.addr = a;
    e.we = 1'b0;
    e.wdata = '0;
    if_addr = a;
    if_req = 1'b1;
    if_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(if_done || (err && !sel)) && t < 200);
    check("fetch_bound", 64'(t < 200), 64'd1);
    tick(1);
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] wd);
    req_t e;
    int   t;
    e.addr = a;
    e.we = we;
    e.wdata = wd;
    d_addr = a;
    d_we = we;
    d_wdata = wd;
    d_req = 1'b1;
    d_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(d_done || (err && sel)) && t < 200);
    check("data_bound", 64'(t < 200), 64'd1);
    tick(1);
    d_req = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    req_t e;
    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    lat_mode = 1;
    tick(3);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_pulses", 64'({if_done, d_done, err}), 64'd0);
    tick(1);
    rst = 1'b1;
    tick(2);

    do_fetch(32'h0000_0100);
    tick(2);
    do_data(32'h0000_2000, 1'b1, 32'hDEAD_BEEF);
    tick(2);

    lat_mode = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) do_data(32'h3000 + 32'(i * 4), 1'b1, 32'(i));
      end
      begin
        for (int i = 0; i < 3; i++) do_fetch(32'h4000 + 32'(i * 4));
      end
    join
    tick(2);

    lat_mode = 255;
    do_fetch(32'h0000_0300);
    tick(2);

    d_addr = 32'h0000_5000;
    d_we = 1'b0;
    d_wdata = '0;
    d_req = 1'b1;
    e.addr = d_addr;
    e.we = 1'b0;
    e.wdata = '0;
    d_q.push_back(e);
    tick(2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    d_req = 1'b0;
    d_q.delete();
    @(negedge clk);
    check("post_rst_en", 64'(mem_en), 64'd0);
    check("post_rst_sel", 64'(sel), 64'd0);
    check("post_rst_done", 64'(d_done), 64'd0);
    tick(1);
    lat_mode = 2;
    do_fetch(32'h0000_0400);
    tick(2);

    lat_mode = -1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          tick(int'($urandom_range(0, 3)));
          do_fetch($urandom & 32'hFFFF_FFFC);
        end
      end
      begin
        for (int i = 0; i < 80; i++) begin
          tick(int'($urandom_range(0, 3)));
          do_data($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom);
        end
      end
    join
    tick(4);
    check("if_q_drained", 64'(if_q.size()), 64'd0);
    check("d_q_drained", 64'(d_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
